audio_dac_stream: RTL
=====================

// Module: audio_dac_stream
// PURPOSE
//  Buffers stereo PCM samples from the synthesis datapath and serialises them to the
//  audio codec DAC. The codec is configured over I2C as a slave in DSP mode B, 16-bit words.
//  Generates BCLK and DACLRCK from clk and shifts left/right words MSB-first, one frame per sample.
//  Sits between the voice mixer (upstream, valid/ready) and the codec pins (downstream).
// PARAMETERS
//  SAMPLE_W   16   bits per channel word
//  FIFO_DEPTH 8    stereo-pair FIFO entries; power of two, >=2
//  BCLK_HALF  8    clk cycles per BCLK half-period; >=2
//  FRAME_BITS 64   BCLK periods per frame; >=2*SAMPLE_W+1
// PORTS
//  clk        in  1         system clock
//  reset      in  1         synchronous, active-low
//  enable     in  1         1 = run serial interface; 0 = idle pins, hold FIFO
//  s_valid    in  1         upstream sample pair valid
//  s_ready    out 1         FIFO can accept a pair; transfer when s_valid&s_ready at posedge clk
//  s_left     in  SAMPLE_W  left sample, two's complement
//  s_right    in  SAMPLE_W  right sample, two's complement
//  bclk       out 1         codec bit clock
//  dac_lrck   out 1         codec DACLRCK, one-BCLK frame-sync pulse
//  dac_data   out 1         codec DACDAT
//  underrun   out 1         1-clk pulse: frame started with FIFO empty
//  fifo_level out clog2(FIFO_DEPTH)+1  entries currently held
// BEHAVIOUR
//  Reset (reset==0 at posedge clk): bclk=0, dac_lrck=0, dac_data=0, underrun=0, s_ready=0.
//   FIFO is emptied (fifo_level=0), divider=0, slot=0, shift register=0. Reset mid-frame aborts it.
//   s_ready rises on the first cycle after reset is released. It is registered and equals !full.
//  FIFO: synchronous, first-word fall-through not required. Push occurs iff s_valid&s_ready.
//   Push and pop in the same cycle are both performed; level is unchanged.
//   When full, s_ready=0 and further data is held upstream. A pop in that cycle does not admit a push.
//   fifo_level is updated in the same cycle as the push/pop. Pointers wrap modulo FIFO_DEPTH.
//  Divider: cnt counts 0..BCLK_HALF-1 while enable=1. At cnt==BCLK_HALF-1 it wraps to 0 and bclk toggles.
//   A 1->0 toggle is a "fall event", a 0->1 toggle a "rise event". Outputs change only on fall events.
//  Slot counter: slot in 0..FRAME_BITS-1, advanced on each fall event, wraps FRAME_BITS-1 -> 0.
//   Outputs registered at the fall event entering slot k:
//   k==0:        pop FIFO into {L,R}, or {0,0} if empty. If empty, underrun=1 for exactly that clk.
//                dac_lrck=1, dac_data=L[SAMPLE_W-1].
//   1..W-1:      dac_lrck=0, dac_data=L[W-1-k].
//   W..2W-1:     dac_data=R[2W-1-k].
//   2W..end:     dac_data=0.
//  The codec samples DACLRCK and DACDAT on the BCLK rising edge, half a BCLK after they change.
//  Sample rate = f_clk/(2*BCLK_HALF*FRAME_BITS); with the defaults this is f_clk/1024 (48.83 kHz at 50 MHz).
//  enable 1->0: at the next clk, bclk=0, dac_lrck=0, dac_data=0, cnt=0, slot=0.
//   Any partial frame is dropped. FIFO contents and push handshake continue unaffected.
//  enable 0->1: the first fall event (after BCLK_HALF rise + BCLK_HALF fall) enters slot 0.
//   No pop or underrun happens while enable=0.
//  Upstream must supply one pair per frame; surplus is absorbed up to FIFO_DEPTH, then back-pressured.
// TESTING
//  1 reset: hold reset=0 5 clk with s_valid=1 -> all outputs 0, fifo_level=0; s_ready=1 on 1st clk after release.
//  2 serial frame: push L=16'hA5C3, R=16'h0F0F, enable=1.
//    -> lrck high for exactly slot 0; DACDAT bits on rising bclk = A5C3 then 0F0F MSB-first, then 32 zeros.
//    -> bclk period = 16 clk; frame = 1024 clk.
//  3 fill/backpressure: push 9 pairs back-to-back with enable=0 -> 8 accepted, s_ready=0, fifo_level=8.
//    -> enabling pops one pair per frame, in order.
//  4 underrun: enable with an empty FIFO -> underrun pulses once per frame, data all 0.
//    -> a pair pushed mid-frame appears in the next frame.
//  5 simultaneous push/pop at level 3 on a slot-0 fall event -> level stays 3, order preserved.
//  6 enable dropped mid-left-word at slot 7 -> next clk pins 0; re-enable -> clean frame from slot 0 with the next FIFO pair.

Source files
------------

// File: rtl/audio_dac_stream.sv
// Stereo PCM FIFO plus DSP-mode-B serialiser for the codec DAC.
// bclk is divided down from clk; outputs update on bclk falling events, and the codec samples them on the following rising edge.
module audio_dac_stream #(
   parameter int SAMPLE_W   = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int BCLK_HALF  = 8,
   parameter int FRAME_BITS = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [SAMPLE_W-1:0]           s_left,
   input  logic [SAMPLE_W-1:0]           s_right,
   output logic                          bclk,
   output logic                          dac_lrck,
   output logic                          dac_data,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(BCLK_HALF);
   localparam int SW = $clog2(FRAME_BITS);
   localparam int DW = 2 * SAMPLE_W;

   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          s_ready_q, s_ready_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bclk_q, bclk_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [DW-1:0] sh_q, sh_d;
   logic          lrck_q, lrck_d, data_q, data_d, underrun_q, underrun_d;
   logic          push, pop, empty, cnt_wrap, fall, frame_start;
   logic [DW-1:0] word;

   always_comb begin
      push        = s_valid & s_ready_q;
      empty       = (level_q == '0);
      cnt_wrap    = (cnt_q == CW'(BCLK_HALF - 1));
      fall        = enable & cnt_wrap & bclk_q;
      // slot_q holds the slot the next fall event enters
      frame_start = fall & (slot_q == '0);
      pop         = frame_start & ~empty;
      word        = empty ? '0 : mem_q[rd_ptr_q];

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      // Registered from the next level, so a pop while full cannot admit a push that cycle
      s_ready_d = (level_d != LW'(FIFO_DEPTH));

      cnt_d      = '0;
      bclk_d     = 1'b0;
      slot_d     = '0;
      sh_d       = '0;
      lrck_d     = 1'b0;
      data_d     = 1'b0;
      underrun_d = 1'b0;
      if (enable) begin
         cnt_d      = cnt_wrap ? '0 : cnt_q + CW'(1);
         bclk_d     = cnt_wrap ? ~bclk_q : bclk_q;
         slot_d     = slot_q;
         sh_d       = sh_q;
         lrck_d     = lrck_q;
         data_d     = data_q;
         underrun_d = frame_start & empty;
         if (fall) begin
            slot_d = (slot_q == SW'(FRAME_BITS - 1)) ? '0 : slot_q + SW'(1);
            lrck_d = (slot_q == '0);
            // Shifting past the right word drains zeros for the frame tail
            if (slot_q == '0) begin
               data_d = word[DW-1];
               sh_d   = word << 1;
            end else begin
               data_d = sh_q[DW-1];
               sh_d   = sh_q << 1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && push) mem_q[wr_ptr_q] <= {s_left, s_right};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         s_ready_q  <= 1'b0;
         cnt_q      <= '0;
         bclk_q     <= 1'b0;
         slot_q     <= '0;
         sh_q       <= '0;
         lrck_q     <= 1'b0;
         data_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         s_ready_q  <= s_ready_d;
         cnt_q      <= cnt_d;
         bclk_q     <= bclk_d;
         slot_q     <= slot_d;
         sh_q       <= sh_d;
         lrck_q     <= lrck_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign bclk       = bclk_q;
   assign dac_lrck   = lrck_q;
   assign dac_data   = data_q;
   assign underrun   = underrun_q;
   assign fifo_level = level_q;
endmodule
